// File: rtl/data_mem_2p_if.sv
// data_mem_2p_if
// Groups the write and read port signals of the dual-port data memory.
//   master : drives wr_en/wr_addr/wr_data and rd_en/rd_addr; receives rd_data/rd_valid
//   slave  : the memory side of the same signals
interface data_mem_2p_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
);
    logic                  wr_en;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;

    modport master (
        output wr_en, rd_en, wr_addr, rd_addr, wr_data,
        input  rd_data, rd_valid
    );

    modport slave (
        input  wr_en, rd_en, wr_addr, rd_addr, wr_data,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/data_mem_2p.sv
// data_mem_2p
// Simple dual-port synchronous RAM used as the frame-buffer data store.
// One write port and one read port on a single clock; read data is
// registered (one-cycle latency). Same-address collisions are write-first.
//   clk   : single clock, all updates on rising edge
//   reset : asynchronous, active-high; clears read outputs (and the array
//           when CLEAR_ON_RESET = 1)
//   bus   : write/read port signals (slave side of data_mem_2p_if)
module data_mem_2p #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 3,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    data_mem_2p_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;
    logic                  collide;

    assign collide = bus.wr_en && (bus.wr_addr == bus.rd_addr);

    generate
        if (CLEAR_ON_RESET) begin : g_clear
            // Register-based array so that every word can be cleared by reset.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        mem[i] <= '0;
                    end
                end else if (bus.wr_en) begin
                    mem[bus.wr_addr] <= bus.wr_data;
                end
            end
        end else begin : g_no_clear
            // No reset on the array keeps it mappable to block RAM; writes
            // are still suppressed while reset is held.
            always_ff @(posedge clk) begin
                if (!reset && bus.wr_en) begin
                    mem[bus.wr_addr] <= bus.wr_data;
                end
            end
        end
    endgenerate

    // Write-first: on a same-address collision forward the incoming word
    // instead of the stale array contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else if (bus.rd_en) begin
            rd_data_q  <= collide ? bus.wr_data : mem[bus.rd_addr];
            rd_valid_q <= 1'b1;
        end else begin
            rd_valid_q <= 1'b0;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
endmodule

// File: tb/tb_data_mem_2p.sv
// tb_data_mem_2p
// Directed self-checking bench for data_mem_2p (DATA_WIDTH=16, ADDR_WIDTH=3,
// 20 ns clock). Inputs change 1 ns after a rising edge; outputs are checked
// at that same point, well away from the next edge.
module tb_data_mem_2p;
    localparam int DW = 16;
    localparam int AW = 3;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fails;

    data_mem_2p_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    data_mem_2p #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_data(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        bus.rd_en   = 1'b0;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b1;
        bus.rd_addr = a;
        tick();
        chk_data(tag, bus.rd_data, exp);
        chk_bit({tag, "_valid"}, bus.rd_valid, 1'b1);
    endtask

    initial begin
        n_checks    = 0;
        n_fails     = 0;
        reset       = 1'b1;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.wr_addr = '0;
        bus.rd_addr = '0;
        bus.wr_data = '0;
        #1;
        chk_data("reset_rd_data", bus.rd_data, 16'h0000);
        chk_bit("reset_rd_valid", bus.rd_valid, 1'b0);
        tick();
        tick();
        reset = 1'b0;

        // 1. Reset check: load data, then assert reset mid-cycle.
        write(3'd3, 16'h1234);
        read_chk("preload_rd3", 3'd3, 16'h1234);
        #5;
        reset = 1'b1;
        #1;
        chk_data("async_rst_rd_data", bus.rd_data, 16'h0000);
        chk_bit("async_rst_rd_valid", bus.rd_valid, 1'b0);
        // Write and read attempted while reset is held must be ignored.
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'd4;
        bus.wr_data = 16'h7777;
        bus.rd_en   = 1'b1;
        bus.rd_addr = 3'd4;
        tick();
        chk_bit("held_rst_rd_valid", bus.rd_valid, 1'b0);
        chk_data("held_rst_rd_data", bus.rd_data, 16'h0000);
        reset     = 1'b0;
        bus.wr_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            read_chk($sformatf("post_rst_rd%0d", i), AW'(i), 16'h0000);
        end

        // 2. Sequential write then read.
        for (int i = 0; i < 4; i++) begin
            write(AW'(i), DW'(i + 1));
        end
        for (int i = 0; i < 4; i++) begin
            read_chk($sformatf("seq_rd%0d", i), AW'(i), DW'(i + 1));
        end

        // 3. Read hold with rd_en low.
        read_chk("hold_pre_rd2", 3'd2, 16'h0003);
        bus.rd_en   = 1'b0;
        bus.rd_addr = 3'd6;
        tick();
        chk_data("hold_rd_data", bus.rd_data, 16'h0003);
        chk_bit("hold_rd_valid", bus.rd_valid, 1'b0);

        // 4. Same-address collision is write-first.
        write(3'd5, 16'h1111);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'd5;
        bus.wr_data = 16'hABCD;
        bus.rd_en   = 1'b1;
        bus.rd_addr = 3'd5;
        tick();
        chk_data("collide_rd_data", bus.rd_data, 16'hABCD);
        chk_bit("collide_rd_valid", bus.rd_valid, 1'b1);
        bus.wr_en = 1'b0;
        read_chk("collide_stored", 3'd5, 16'hABCD);

        // Independent ports: write addr 6 while reading addr 1.
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'd6;
        bus.wr_data = 16'h5A5A;
        bus.rd_en   = 1'b1;
        bus.rd_addr = 3'd1;
        tick();
        chk_data("indep_rd1", bus.rd_data, 16'h0002);
        bus.wr_en = 1'b0;
        read_chk("indep_rd6", 3'd6, 16'h5A5A);

        // 5. Boundary addresses, no aliasing.
        write(3'd7, 16'hFFFF);
        write(3'd0, 16'h00A5);
        read_chk("bound_rd7", 3'd7, 16'hFFFF);
        read_chk("bound_rd0", 3'd0, 16'h00A5);

        // 6. Write disabled leaves the array untouched.
        bus.wr_en   = 1'b0;
        bus.wr_addr = 3'd2;
        bus.wr_data = 16'hDEAD;
        bus.rd_en   = 1'b0;
        tick();
        read_chk("wr_dis_rd2", 3'd2, 16'h0003);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/data_mem_2p.md
Name: data_mem_2p

Overview:
- Simple dual-port synchronous RAM: one write port and one read port, sharing a single clock.
- Serves as the frame-buffer data store. Depth is 2**ADDR_WIDTH words of DATA_WIDTH bits.
- Read data is registered, giving one-cycle latency.
- Contents and outputs are cleared by reset.

Parameters:
- DATA_WIDTH, 16, width of each word in bits.
- ADDR_WIDTH, 3, address width; depth = 2**ADDR_WIDTH.
- CLEAR_ON_RESET, 1, when 1 the reset zeroes every array word; when 0 reset clears only output registers.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- wr_en  input  1  write enable, active-high.
- rd_en  input  1  read enable, active-high.
- wr_addr  input  ADDR_WIDTH  write address.
- rd_addr  input  ADDR_WIDTH  read address.
- wr_data  input  DATA_WIDTH  write data.
- rd_data  output  DATA_WIDTH  registered read data.
- rd_valid  output  1  high for the cycle after an accepted read; may be left unconnected.

Behaviour:
- Clocking: one clock (clk). Reset is asynchronous and active-high; no other clock domains.
- Reset asserted, at any time (including mid-operation):
  - rd_data = 0 and rd_valid = 0 immediately, without waiting for a clock edge.
  - If CLEAR_ON_RESET = 1, all array words become 0.
  - While reset is high, writes and reads are ignored.
- Reset deassertion:
  - The first rising edge with reset low is a normal operating edge.
  - Deassertion should be synchronized externally; the block does not synchronize it.
- Write: on a rising edge with wr_en = 1, mem[wr_addr] <= wr_data. With wr_en = 0 the array is unchanged.
- Read:
  - On a rising edge with rd_en = 1: rd_data <= mem[rd_addr] and rd_valid <= 1.
  - With rd_en = 0: rd_data holds its previous value and rd_valid <= 0.
  - Latency: the address applied at edge N appears on rd_data after edge N; valid for the whole cycle N..N+1.
- Same-edge collision (wr_en = rd_en = 1, wr_addr == rd_addr): write-first. rd_data takes the new wr_data, not the old contents.
- Different addresses on the same edge: the ports are fully independent.
- Addressing:
  - Every ADDR_WIDTH value is a valid location; there is no out-of-range case and no wrap logic.
  - Address 2**ADDR_WIDTH-1 is the last word.
- Unwritten locations read 0 after reset when CLEAR_ON_RESET = 1. When CLEAR_ON_RESET = 0 they read undefined.
- No handshake or back-pressure: one write and one read can be accepted every cycle.
- No internal arithmetic; data is stored bit-exact at DATA_WIDTH.
- The array is inferable as block RAM when CLEAR_ON_RESET = 0. When it is 1, the array is register-based.

Test Plan (all scenarios use DATA_WIDTH=16, ADDR_WIDTH=3, 20 ns clock):
1. Reset check: assert reset mid-cycle after loading data -> rd_data = 0x0000 and rd_valid = 0 before the next edge. After release, reading addresses 0..7 returns 0x0000.
2. Sequential write/read: write 0x0001, 0x0002, 0x0003, 0x0004 to addresses 0..3; then read 0..3 with rd_en = 1 -> rd_data = 0x0001..0x0004, each one edge after its address, with rd_valid = 1.
3. Read hold: after reading 0x0003, drop rd_en and change rd_addr -> rd_data stays 0x0003 and rd_valid = 0.
4. Collision: address 5 holds 0x1111; on one edge write 0xABCD to address 5 and read address 5 -> rd_data = 0xABCD.
5. Boundary: write 0xFFFF to address 7 and 0x00A5 to address 0, then read both -> 0xFFFF and 0x00A5. No aliasing between the two addresses.
6. Write disabled: wr_en = 0 while wr_data = 0xDEAD and wr_addr = 2 -> address 2 keeps 0x0003 on read-back.
